// File: rtl/risc_run_ctrl.sv
// Run controller for the pipelined Risc core: sequences core reset, free-run and
// N-cycle single-step execution from a host command handshake, and counts enabled cycles.
module risc_run_ctrl #(
    parameter int unsigned CYCLE_W    = 32,
    parameter int unsigned TIMEOUT    = 100000,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [15:0]        cmd_count,
    input  logic               core_halt,
    output logic               core_rst_n,
    output logic               core_en,
    output logic               busy,
    output logic [2:0]         state,
    output logic               done,
    output logic [1:0]         done_code,
    output logic [CYCLE_W-1:0] cycle_count
);

    localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    localparam logic [1:0] CODE_HALTED  = 2'b00;
    localparam logic [1:0] CODE_STEPS   = 2'b01;
    localparam logic [1:0] CODE_STOPPED = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_RUN   = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             cur_state;
    state_t             next_state;
    logic [1:0]         next_code;
    logic               accept;
    logic [RST_W-1:0]   rst_cnt;
    logic [CYCLE_W-1:0] tmo_cnt;
    logic [15:0]        remaining;
    logic               tmo_hit;

    assign state = cur_state;

    // Next-state decode; within RUN/STEP the if-chain order is the exit priority.
    always_comb begin
        next_state = cur_state;
        next_code  = done_code;
        accept     = cmd_valid && cmd_ready;
        tmo_hit    = (TIMEOUT != 0) && (tmo_cnt == CYCLE_W'(TIMEOUT - 1));
        unique case (cur_state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_RESET: next_state = S_RESET;
                        OP_RUN:   next_state = S_RUN;
                        OP_STEP: begin
                            if (cmd_count == 16'd0) begin
                                next_state = S_DONE;
                                next_code  = CODE_STEPS;
                            end else begin
                                next_state = S_STEP;
                            end
                        end
                        default: next_state = S_IDLE;
                    endcase
                end
            end
            S_RESET: begin
                if (rst_cnt == RST_W'(RST_CYCLES - 1)) next_state = S_IDLE;
            end
            S_RUN, S_STEP: begin
                if (accept && cmd_op == OP_RESET) begin
                    next_state = S_RESET;
                end else if (core_halt) begin
                    next_state = S_DONE;
                    next_code  = CODE_HALTED;
                end else if (accept && cmd_op == OP_STOP) begin
                    next_state = S_DONE;
                    next_code  = CODE_STOPPED;
                end else if (cur_state == S_STEP && remaining == 16'd1) begin
                    next_state = S_DONE;
                    next_code  = CODE_STEPS;
                end else if (cur_state == S_RUN && tmo_hit) begin
                    next_state = S_DONE;
                    next_code  = CODE_TIMEOUT;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State, counters and Moore outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state   <= S_RESET;
            rst_cnt     <= '0;
            tmo_cnt     <= '0;
            remaining   <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            done_code   <= CODE_HALTED;
            core_en     <= 1'b0;
            core_rst_n  <= 1'b0;
            busy        <= 1'b1;
            cmd_ready   <= 1'b0;
        end else begin
            cur_state  <= next_state;
            done       <= (next_state == S_DONE);
            done_code  <= next_code;
            core_en    <= (next_state == S_RUN) || (next_state == S_STEP);
            core_rst_n <= (next_state != S_RESET);
            busy       <= (next_state != S_IDLE);
            cmd_ready  <= (next_state == S_IDLE) || (next_state == S_RUN) ||
                          (next_state == S_STEP);

            if (cur_state == S_RESET && next_state == S_RESET) rst_cnt <= rst_cnt + RST_W'(1);
            else                                               rst_cnt <= '0;

            if (cur_state == S_RUN && next_state == S_RUN) tmo_cnt <= tmo_cnt + CYCLE_W'(1);
            else                                           tmo_cnt <= '0;

            if (cur_state == S_IDLE && next_state == S_STEP)      remaining <= cmd_count;
            else if (cur_state == S_STEP && next_state == S_STEP) remaining <= remaining - 16'd1;

            // Clearing on reset entry overrides the increment of the last enabled cycle.
            if (next_state == S_RESET && cur_state != S_RESET) cycle_count <= '0;
            else if (core_en && cycle_count != '1)             cycle_count <= cycle_count + CYCLE_W'(1);
        end
    end

endmodule

// File: tb/tb_risc_run_ctrl.sv
// Directed bench for risc_run_ctrl: a default-timeout instance for step/halt/reset
// scenarios and a TIMEOUT=16 instance for stop and timeout scenarios.
module tb_risc_run_ctrl;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        t_cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_count;
    logic        core_halt;

    logic        cmd_ready, core_rst_n, core_en, busy, done;
    logic [2:0]  state;
    logic [1:0]  done_code;
    logic [31:0] cycle_count;

    logic        t_cmd_ready, t_core_rst_n, t_core_en, t_busy, t_done;
    logic [2:0]  t_state;
    logic [1:0]  t_done_code;
    logic [31:0] t_cycle_count;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt;
    int done_cnt;
    int done_at;
    int rst_low;
    int rdy_seen;
    logic [1:0] last_code;

    risc_run_ctrl #(.CYCLE_W(32), .TIMEOUT(100000), .RST_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .core_halt(core_halt),
        .core_rst_n(core_rst_n), .core_en(core_en), .busy(busy), .state(state),
        .done(done), .done_code(done_code), .cycle_count(cycle_count)
    );

    risc_run_ctrl #(.CYCLE_W(32), .TIMEOUT(16), .RST_CYCLES(2)) dut_t (
        .clk(clk), .rst(rst), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .core_halt(core_halt),
        .core_rst_n(t_core_rst_n), .core_en(t_core_en), .busy(t_busy), .state(t_state),
        .done(t_done), .done_code(t_done_code), .cycle_count(t_cycle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input bit tsel, input logic v);
        if (tsel) t_cmd_valid = v;
        else      cmd_valid   = v;
    endtask

    // Issue one command, then observe ncyc cycles with optional halt and injected commands.
    task automatic run_seq(input bit tsel, input logic [1:0] op, input logic [15:0] cnt,
                           input int ncyc, input int halt_at,
                           input int a_at, input logic [1:0] a_op,
                           input int b_at, input logic [1:0] b_op, input int b_len);
        logic       en, dn, rn;
        logic [1:0] dc;
        cmd_op    = op;
        cmd_count = cnt;
        set_valid(tsel, 1'b1);
        tick();
        set_valid(tsel, 1'b0);
        en_cnt    = 0;
        done_cnt  = 0;
        done_at   = -1;
        rst_low   = 0;
        rdy_seen  = -1;
        last_code = 2'bxx;
        for (int i = 0; i < ncyc; i++) begin
            if (i == halt_at) core_halt = 1'b1;
            set_valid(tsel, 1'b0);
            if (i == a_at) begin
                cmd_op = a_op;
                set_valid(tsel, 1'b1);
            end
            if (i >= b_at && i < b_at + b_len) begin
                cmd_op = b_op;
                set_valid(tsel, 1'b1);
            end
            if (i == b_at) rdy_seen = tsel ? int'(t_cmd_ready) : int'(cmd_ready);
            en = tsel ? t_core_en    : core_en;
            dn = tsel ? t_done       : done;
            rn = tsel ? t_core_rst_n : core_rst_n;
            dc = tsel ? t_done_code  : done_code;
            if (en) en_cnt++;
            if (!rn) rst_low++;
            if (dn) begin
                done_cnt++;
                last_code = dc;
                if (done_at < 0) done_at = i;
            end
            tick();
        end
        core_halt = 1'b0;
        set_valid(tsel, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (state !== 3'd1 || core_rst_n !== 1'b0 || core_en !== 1'b0 ||
            cmd_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ctl: state=%0d rst_n=%b en=%b rdy=%b busy=%b, want 1 0 0 0 1",
                     state, core_rst_n, core_en, cmd_ready, busy);
        end
        n_checks++;
        if (done !== 1'b0 || done_code !== 2'b00 || cycle_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stat: done=%b code=%b cyc=%0d, want 0 00 0",
                     done, done_code, cycle_count);
        end
        tick();
        n_checks++;
        if (core_rst_n !== 1'b0 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_len2: rst_n=%b state=%0d, want 0 1", core_rst_n, state);
        end
        tick();
        n_checks++;
        if (state !== 3'd0 || cmd_ready !== 1'b1 || core_rst_n !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_exit: state=%0d rdy=%b rst_n=%b busy=%b, want 0 1 1 0",
                     state, cmd_ready, core_rst_n, busy);
        end
    endtask

    task automatic test_step();
        run_seq(1'b0, OP_STEP, 16'd5, 12, -1, -1, OP_RUN, -1, OP_RUN, 0);
        n_checks++;
        if (en_cnt != 5 || done_cnt != 1 || done_at != 5 || last_code !== 2'b01) begin
            n_fail++;
            $display("FAIL step5: en=%0d done=%0d at=%0d code=%b, want 5 1 5 01",
                     en_cnt, done_cnt, done_at, last_code);
        end
        n_checks++;
        if (cycle_count !== 32'd5) begin
            n_fail++;
            $display("FAIL step5_cyc: got %0d want 5", cycle_count);
        end
        run_seq(1'b0, OP_STEP, 16'd3, 10, -1, -1, OP_RUN, -1, OP_RUN, 0);
        n_checks++;
        if (en_cnt != 3 || done_cnt != 1 || done_at != 3 || cycle_count !== 32'd8) begin
            n_fail++;
            $display("FAIL step3: en=%0d done=%0d at=%0d cyc=%0d, want 3 1 3 8",
                     en_cnt, done_cnt, done_at, cycle_count);
        end
    endtask

    task automatic test_step_zero();
        run_seq(1'b0, OP_STEP, 16'd0, 5, -1, -1, OP_RUN, -1, OP_RUN, 0);
        n_checks++;
        if (en_cnt != 0 || done_cnt != 1 || done_at != 0 || last_code !== 2'b01 ||
            cycle_count !== 32'd8) begin
            n_fail++;
            $display("FAIL step0: en=%0d done=%0d at=%0d code=%b cyc=%0d, want 0 1 0 01 8",
                     en_cnt, done_cnt, done_at, last_code, cycle_count);
        end
    endtask

    task automatic test_run_halt();
        run_seq(1'b0, OP_RUN, 16'd0, 45, 39, -1, OP_RUN, -1, OP_RUN, 0);
        n_checks++;
        if (en_cnt != 40 || done_cnt != 1 || done_at != 40 || last_code !== 2'b00) begin
            n_fail++;
            $display("FAIL run_halt: en=%0d done=%0d at=%0d code=%b, want 40 1 40 00",
                     en_cnt, done_cnt, done_at, last_code);
        end
        n_checks++;
        if (cycle_count !== 32'd48 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL run_halt_cyc: cyc=%0d state=%0d, want 48 0", cycle_count, state);
        end
    endtask

    task automatic test_halt_stop_same_edge();
        run_seq(1'b0, OP_RUN, 16'd0, 45, 39, 39, OP_STOP, -1, OP_RUN, 0);
        n_checks++;
        if (en_cnt != 40 || done_cnt != 1 || last_code !== 2'b00 || cycle_count !== 32'd88) begin
            n_fail++;
            $display("FAIL halt_stop: en=%0d done=%0d code=%b cyc=%0d, want 40 1 00 88",
                     en_cnt, done_cnt, last_code, cycle_count);
        end
    endtask

    task automatic test_stop();
        run_seq(1'b1, OP_RUN, 16'd0, 12, -1, 6, OP_STOP, -1, OP_RUN, 0);
        n_checks++;
        if (en_cnt != 7 || done_cnt != 1 || done_at != 7 || last_code !== 2'b10) begin
            n_fail++;
            $display("FAIL stop: en=%0d done=%0d at=%0d code=%b, want 7 1 7 10",
                     en_cnt, done_cnt, done_at, last_code);
        end
        n_checks++;
        if (t_cycle_count !== 32'd7) begin
            n_fail++;
            $display("FAIL stop_cyc: got %0d want 7", t_cycle_count);
        end
    endtask

    task automatic test_timeout();
        run_seq(1'b1, OP_RUN, 16'd0, 24, -1, -1, OP_RUN, -1, OP_RUN, 0);
        n_checks++;
        if (en_cnt != 16 || done_cnt != 1 || done_at != 16 || last_code !== 2'b11) begin
            n_fail++;
            $display("FAIL timeout: en=%0d done=%0d at=%0d code=%b, want 16 1 16 11",
                     en_cnt, done_cnt, done_at, last_code);
        end
        n_checks++;
        if (t_cycle_count !== 32'd23 || t_done_code !== 2'b11) begin
            n_fail++;
            $display("FAIL timeout_hold: cyc=%0d code=%b, want 23 11", t_cycle_count, t_done_code);
        end
    endtask

    task automatic test_reset_mid_step();
        run_seq(1'b0, OP_STEP, 16'd100, 20, -1, 10, OP_RESET, 11, OP_RUN, 2);
        n_checks++;
        if (en_cnt != 11 || done_cnt != 0 || rst_low != 2) begin
            n_fail++;
            $display("FAIL mid_reset: en=%0d done=%0d rst_low=%0d, want 11 0 2",
                     en_cnt, done_cnt, rst_low);
        end
        n_checks++;
        if (rdy_seen != 0) begin
            n_fail++;
            $display("FAIL mid_reset_rdy: cmd_ready in RESET=%0d want 0", rdy_seen);
        end
        n_checks++;
        if (cycle_count !== 32'd0 || state !== 3'd0 || core_en !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_end: cyc=%0d state=%0d en=%b, want 0 0 0",
                     cycle_count, state, core_en);
        end
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        t_cmd_valid = 1'b0;
        cmd_op      = OP_RUN;
        cmd_count   = 16'd0;
        core_halt   = 1'b0;
        test_reset();
        test_step();
        test_step_zero();
        test_run_halt();
        test_halt_stop_same_edge();
        test_stop();
        test_timeout();
        test_reset_mid_step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/risc_run_ctrl.md
# risc_run_ctrl

Run controller for the pipelined `Risc` core. It owns the core's `en` and `rst_n` inputs and sequences reset, free-run and N-cycle single-step execution from a host command handshake. It detects program completion through the core's `halt` output and counts enabled cycles. It sits between the testbench/host interface and the core.

## Interface
Parameters:
- `CYCLE_W`, 32: width of the cycle counter and the timeout counter.
- `TIMEOUT`, 100000: maximum number of cycles in RUN before the run aborts. 0 disables the timeout.
- `RST_CYCLES`, 2: number of cycles `core_rst_n` is held low per core reset (≥1).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: host command valid.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_op` in 2: 00 RESET_CORE, 01 RUN, 10 STEP, 11 STOP.
- `cmd_count` in 16: step count, used by STEP only.
- `core_halt` in 1: the core's `halt` output.
- `core_rst_n` out 1: drives the core's `rst_n`.
- `core_en` out 1: drives the core's `en`.
- `busy` out 1: high whenever state ≠ IDLE.
- `state` out 3: IDLE=0, RESET=1, RUN=2, STEP=3, DONE=4.
- `done` out 1: one-cycle pulse marking the end of a RUN or STEP.
- `done_code` out 2: 00 HALTED, 01 STEPS_DONE, 10 STOPPED, 11 TIMEOUT. Held until the next DONE.
- `cycle_count` out CYCLE_W: number of cycles with `core_en`=1 since the last core reset. Saturates at all-ones.

## Operation
- A command is accepted on a rising edge with `cmd_valid && cmd_ready`.
- `cmd_ready` is 1 in IDLE, RUN and STEP, and 0 in RESET and DONE.
- Outputs are Moore-decoded from state:
  - `core_en` = (state==RUN || state==STEP).
  - `core_rst_n` = (state != RESET).
- IDLE:
  - RESET_CORE → RESET.
  - RUN → RUN, clearing the timeout counter.
  - STEP with `cmd_count`=0 → DONE with code 01, `core_en` never asserted.
  - STEP with `cmd_count`=n>0 → STEP, loading `remaining`=n.
  - STOP is accepted and ignored.
  - `core_halt` is ignored.
- RESET:
  - A counter runs RST_CYCLES cycles, then the state goes to IDLE.
  - `cycle_count` is cleared on entry.
- RUN / STEP: exit conditions, evaluated each edge in this priority order:
  1. Accepted RESET_CORE → RESET. No `done` pulse.
  2. `core_halt`=1 → DONE, code 00.
  3. Accepted STOP → DONE, code 10.
  4. STEP: `remaining`==1 → DONE, code 01. Otherwise `remaining` decrements.
  5. RUN: TIMEOUT≠0 and timeout counter == TIMEOUT-1 → DONE, code 11. Otherwise the timeout counter increments.
- RUN / STEP: RUN and STEP commands accepted in these states are dropped without effect.
- DONE: `done`=1 and `done_code` is updated for exactly one cycle, then the state goes to IDLE. The core keeps its register state, so a following RUN or STEP resumes from the current pc.
- `cycle_count` increments by 1 on every edge where `core_en`=1, saturating at all-ones.

## Timing
- On `rst`=1 at an edge, the next cycle shows:
  - state=RESET, `core_rst_n`=0, `core_en`=0, `cmd_ready`=0, `busy`=1.
  - `done`=0, `done_code`=00, `cycle_count`=0, internal counters 0.
- After that, RESET runs its normal RST_CYCLES sequence. `rst` asserted mid-RUN, mid-STEP or mid-DONE behaves identically and suppresses any pending `done` pulse.
- Command accepted at edge T: the new state and its outputs are visible from T+1. `core_en` rises at T+1.
- STEP n: `core_en` is high for exactly n consecutive cycles, `done` is asserted on the cycle after the last of them, and `cycle_count` increases by n.
- RUN with TIMEOUT=k: `core_en` is high for exactly k cycles when there is no halt and no STOP.
- Halt: if `core_halt` is 1 at the first edge in RUN, `core_en` is high for exactly 1 cycle.
- Halt and STOP on the same edge: HALTED wins.
- Halt on the last step edge: HALTED wins.
- Reset length: RESET_CORE accepted at T gives `core_rst_n` low for cycles T+1 .. T+RST_CYCLES, and IDLE with `cmd_ready`=1 from T+RST_CYCLES+1.
- No combinational path from any input to any output.

## Test plan
- Reset: `rst` pulse with RST_CYCLES=2 → `core_rst_n`=0 for 2 cycles, then IDLE with `cmd_ready`=1; `cycle_count`=0, `done_code`=00.
- STEP 5 from IDLE → `core_en` high exactly 5 cycles, one `done` with code 01, `cycle_count`=5. A second STEP 3 → `cycle_count`=8.
- STEP 0 → `core_en` never high, DONE next cycle with code 01, `cycle_count` unchanged.
- RUN, with `core_halt` driven high 40 cycles after entry → `done` with code 00, `core_en` high exactly 40 cycles. Repeat with STOP accepted on the same edge as halt → code 00.
- RUN with TIMEOUT=16 and `core_halt`=0 → code 11 after 16 enabled cycles. STOP accepted after 7 cycles → code 10, `cycle_count`=7.
- RESET_CORE issued mid-STEP 100 → no `done` pulse, `core_rst_n` low for RST_CYCLES, `cycle_count` cleared. A RUN command issued while in RESET sees `cmd_ready`=0 and is not accepted.
